// File: rtl/uart_boot_loader.sv
// uart_boot_loader: parses a framed byte stream into little-endian RAM word writes, then releases the CPU.
// Optional checksum byte and state enabled by defining BOOT_CHECKSUM_EN.
module uart_boot_loader #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 1_000_000,
  parameter int          CNT_W          = 16
) (
  input  logic             clk,
  input  logic             i_reset,
  input  logic             i_rx_valid,
  input  logic [7:0]       i_rx_data,
  output logic             o_wr_valid,
  output logic [31:0]      o_wr_addr,
  output logic [31:0]      o_wr_data,
  output logic             o_cpu_running,
  output logic             o_busy,
  output logic             o_error,
  output logic [CNT_W-1:0] o_word_count
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
`ifdef BOOT_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LEN, DATA, CSUM, RUN, ERR} state_t;
  localparam state_t FIN = CSUM;
  logic [7:0] csum;
`else
  typedef enum logic [2:0] {IDLE, LEN, DATA, RUN, ERR} state_t;
  localparam state_t FIN = RUN;
`endif
  state_t state, state_d;
  logic [1:0]       bc;
  logic [7:0]       n_lo;
  logic [CNT_W-1:0] n;
  logic [23:0]      shift;
  logic [TW-1:0]    tmo;
  logic [CNT_W-1:0] len;
  logic             in_frame, in_frame_d, start, expire;
  assign len        = CNT_W'({i_rx_data, n_lo});
  assign in_frame   = state != IDLE && state != RUN && state != ERR;
  assign in_frame_d = state_d != IDLE && state_d != RUN && state_d != ERR;
  assign start      = i_rx_valid && i_rx_data == SYNC_BYTE && (state == IDLE || state == ERR);
  assign expire     = in_frame && !i_rx_valid && tmo == TW'(TIMEOUT_CYCLES - 1);
  always_comb begin
    state_d = state;
    case (state)
      IDLE, ERR: state_d = start ? LEN : state;
      LEN:       if (i_rx_valid && bc[0])
                   state_d = len > CNT_W'(MAX_WORDS) ? ERR : len == '0 ? FIN : DATA;
      DATA:      if (i_rx_valid && bc == 2'd3 && o_word_count == n - CNT_W'(1)) state_d = FIN;
`ifdef BOOT_CHECKSUM_EN
      CSUM:      if (i_rx_valid) state_d = i_rx_data == csum ? RUN : ERR;
`endif
      default:   state_d = state;
    endcase
    if (expire) state_d = ERR;
  end
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      state         <= IDLE;
      bc            <= '0;
      n_lo          <= '0;
      n             <= '0;
      shift         <= '0;
      tmo           <= '0;
      o_wr_valid    <= 1'b0;
      o_wr_addr     <= '0;
      o_wr_data     <= '0;
      o_cpu_running <= 1'b0;
      o_busy        <= 1'b0;
      o_error       <= 1'b0;
      o_word_count  <= '0;
`ifdef BOOT_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state         <= state_d;
      o_wr_valid    <= 1'b0;
      o_busy        <= in_frame_d;
      o_error       <= state_d == ERR;
      o_cpu_running <= state_d == RUN;
      tmo           <= in_frame && !i_rx_valid ? tmo + TW'(1) : '0;
      if (start) begin
        bc           <= '0;
        o_word_count <= '0;
`ifdef BOOT_CHECKSUM_EN
        csum         <= '0;
`endif
      end
      if (i_rx_valid && state == LEN) begin
        n_lo <= i_rx_data;
        n    <= len;
        bc   <= {1'b0, ~bc[0]};
`ifdef BOOT_CHECKSUM_EN
        csum <= csum ^ i_rx_data;
`endif
      end
      if (i_rx_valid && state == DATA) begin
        bc    <= bc + 2'd1;
        shift <= {i_rx_data, shift[23:8]};
`ifdef BOOT_CHECKSUM_EN
        csum  <= csum ^ i_rx_data;
`endif
        if (bc == 2'd3) begin
          o_wr_valid   <= 1'b1;
          o_wr_addr    <= BASE_ADDR + 32'({o_word_count, 2'b00});
          o_wr_data    <= {i_rx_data, shift};
          o_word_count <= o_word_count + CNT_W'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_uart_boot_loader.sv
// tb_uart_boot_loader: randomized frames checked against a frame-level model of expected writes and flags.
module tb_uart_boot_loader;
  localparam int TMO = 40;
  localparam logic [31:0] BASE = 32'h0000_0000;
  logic        clk = 0, i_reset = 1, i_rx_valid = 0;
  logic [7:0]  i_rx_data = 0;
  logic        o_wr_valid, o_cpu_running, o_busy, o_error;
  logic [31:0] o_wr_addr, o_wr_data;
  logic [15:0] o_word_count;
  int tests = 0, fails = 0, max_gap = 2;
  logic [31:0] got_a[$], got_d[$], words[$];

  always #5 clk = ~clk;

  uart_boot_loader #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .i_reset(i_reset), .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data),
    .o_wr_valid(o_wr_valid), .o_wr_addr(o_wr_addr), .o_wr_data(o_wr_data),
    .o_cpu_running(o_cpu_running), .o_busy(o_busy), .o_error(o_error),
    .o_word_count(o_word_count)
  );

  always @(negedge clk) if (o_wr_valid) begin
    got_a.push_back(o_wr_addr);
    got_d.push_back(o_wr_data);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int rg();
    return max_gap == 0 ? 0 : int'($urandom_range(0, max_gap));
  endfunction

  task automatic tx(input logic [7:0] b, input int g);
    @(negedge clk);
    i_rx_valid = 1;
    i_rx_data  = b;
    if (g > 0) begin
      @(negedge clk);
      i_rx_valid = 0;
      repeat (g - 1) @(negedge clk);
    end
  endtask

  task automatic idle(input int m);
    @(negedge clk);
    i_rx_valid = 0;
    repeat (m) @(negedge clk);
  endtask

  task automatic send_frame(input int n, input bit bad);
    logic [7:0] x, b;
    logic [15:0] nn;
    nn = 16'(n);
    x = nn[7:0] ^ nn[15:8];
    tx(8'hA5, rg());
    tx(nn[7:0], rg());
    tx(nn[15:8], rg());
    for (int i = 0; i < n; i++)
      for (int k = 0; k < 4; k++) begin
        b = words[i][8*k +: 8];
        x ^= b;
        tx(b, rg());
      end
`ifdef BOOT_CHECKSUM_EN
    tx(bad ? ~x : x, rg());
`endif
    idle(3);
  endtask

  task automatic exp_writes(input string tag, input int n);
    chk({tag, "_nwr"}, 32'(got_a.size()), 32'(n));
    if (got_a.size() == n)
      for (int i = 0; i < n; i++) begin
        chk({tag, "_addr"}, got_a[i], BASE + 32'(4 * i));
        chk({tag, "_data"}, got_d[i], words[i]);
      end
    got_a.delete();
    got_d.delete();
  endtask

  task automatic flags(input string tag, input bit run, input bit err, input int wc);
    chk({tag, "_run"}, 32'(o_cpu_running), 32'(run));
    chk({tag, "_err"}, 32'(o_error), 32'(err));
    chk({tag, "_busy"}, 32'(o_busy), 32'(0));
    chk({tag, "_wc"}, 32'(o_word_count), 32'(wc));
  endtask

  task automatic rst_dut();
    i_reset = 0;
    repeat (2) @(negedge clk);
    i_reset = 1;
    got_a.delete();
    got_d.delete();
    @(negedge clk);
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
  endtask

  initial begin
    int n;
    #1 i_reset = 0;
    #1;
    chk("rst_wv", 32'(o_wr_valid), 0);
    chk("rst_addr", o_wr_addr, 0);
    chk("rst_data", o_wr_data, 0);
    flags("rst", 0, 0, 0);
    rst_dut();

    words = '{32'h12345678, 32'hDEADBEEF};
    send_frame(2, 0);
    exp_writes("basic", 2);
    flags("basic", 1, 0, 2);

    tx(8'hA5, 0); tx(8'h01, 0); tx(8'h00, 0);
    tx(8'hAA, 1); tx(8'hBB, 0); tx(8'hCC, 0); tx(8'hDD, 0);
    idle(3);
    exp_writes("locked", 0);
    flags("locked", 1, 0, 2);

    rst_dut();
    tx(8'h00, 1); tx(8'hFF, 0); tx(8'h13, 2);
    words.delete();
    send_frame(0, 0);
    exp_writes("empty", 0);
    flags("empty", 1, 0, 0);

    rst_dut();
    tx(8'hA5, 0); tx(8'h01, 0); tx(8'h04, 0);
    idle(3);
    exp_writes("toobig", 0);
    flags("toobig", 0, 1, 0);
    n = $urandom_range(1, 6);
    rand_words(n);
    send_frame(n, 0);
    exp_writes("recover", n);
    flags("recover", 1, 0, n);

    rst_dut();
    tx(8'hA5, 0); tx(8'h01, 1); tx(8'h00, 0); tx(8'h11, 2); tx(8'h22, 0);
    idle(TMO - 1);
    chk("tmo_pre_err", 32'(o_error), 0);
    chk("tmo_pre_busy", 32'(o_busy), 1);
    @(negedge clk);
    chk("tmo_err", 32'(o_error), 1);
    chk("tmo_busy", 32'(o_busy), 0);
    exp_writes("tmo", 0);

`ifdef BOOT_CHECKSUM_EN
    rst_dut();
    n = $urandom_range(1, 4);
    rand_words(n);
    send_frame(n, 1);
    exp_writes("badsum", n);
    flags("badsum", 0, 1, n);
    send_frame(n, 0);
    exp_writes("goodsum", n);
    flags("goodsum", 1, 0, n);
`endif

    for (int t = 0; t < 4; t++) begin
      rst_dut();
      max_gap = t == 0 ? 0 : 3;
      n = $urandom_range(1, 8);
      rand_words(n);
      send_frame(n, 0);
      exp_writes("rand", n);
      flags("rand", 1, 0, n);
    end
    max_gap = 2;

    rst_dut();
    tx(8'hA5, 0); tx(8'h02, 0); tx(8'h00, 0);
    tx(8'h01, 0); tx(8'h02, 0); tx(8'h03, 0); tx(8'h04, 0);
    tx(8'h05, 0); tx(8'h06, 0);
    idle(1);
    chk("mid_busy", 32'(o_busy), 1);
    chk("mid_wc", 32'(o_word_count), 1);
    chk("mid_nwr", 32'(got_a.size()), 1);
    #2 i_reset = 0;
    #1;
    chk("mid_wv", 32'(o_wr_valid), 0);
    flags("mid", 0, 0, 0);
    #2 i_reset = 1;
    idle(5);
    chk("mid_after_nwr", 32'(got_a.size()), 1);
    chk("mid_after_run", 32'(o_cpu_running), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
